// File: rtl/riscv_i32_trace_pack_if.sv
// Trace-pack bus: per-cycle retire bundle in, packed branch-trace records out.
interface riscv_i32_trace_pack_if #(
    parameter int DEPTH = 16
);
    logic                     trace__instr_valid;
    logic [31:0]              trace__instr_pc;
    logic                     trace__branch_taken;
    logic [31:0]              trace__branch_target;
    logic                     trace__trap;
    logic                     riscv_clk_enable;
    logic                     trace_enable;
    logic                     rd_ready;
    logic                     rd_valid;
    logic [63:0]              rd_data;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic                     dropped;

    modport master (
        output trace__instr_valid, trace__instr_pc,
        output trace__branch_taken, trace__branch_target,
        output trace__trap, riscv_clk_enable, trace_enable,
        output rd_ready,
        input  rd_valid, rd_data, fifo_level, dropped
    );

    modport slave (
        input  trace__instr_valid, trace__instr_pc,
        input  trace__branch_taken, trace__branch_target,
        input  trace__trap, riscv_clk_enable, trace_enable,
        input  rd_ready,
        output rd_valid, rd_data, fifo_level, dropped
    );
endinterface

// File: rtl/riscv_i32_trace_pack.sv
// Compresses the retire trace into 64-bit discontinuity records
// and buffers them in a FIFO drained by a valid/ready reader.
module riscv_i32_trace_pack #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 14
) (
    input logic clk,
    input logic clk__enable,
    input logic reset,
    riscv_i32_trace_pack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        REC_SYNC   = 2'd0,
        REC_BRANCH = 2'd1,
        REC_TRAP   = 2'd2,
        REC_SAT    = 2'd3
    } rec_t;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] rcnt;
    logic             sync_pending;
    logic             dropped;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic [63:0]      mem [DEPTH];

    logic        ev;
    logic        gen;
    logic        gen_rec;
    logic        full;
    logic        push_ok;
    logic        push_drop;
    logic        pop;
    logic        rd_valid;
    rec_t        rtype;
    logic [31:0] raddr;
    logic [63:0] rec;

    assign ev = clk__enable & bus.riscv_clk_enable
              & bus.trace_enable & bus.trace__instr_valid;
    assign n  = cnt + CNT_W'(1);

    always_comb begin
        gen     = 1'b1;
        rtype   = REC_SYNC;
        raddr   = bus.trace__instr_pc;
        rcnt    = n;
        cnt_nxt = '0;
        if (bus.trace__trap) begin
            rtype = REC_TRAP;
        end else if (bus.trace__branch_taken) begin
            rtype = REC_BRANCH;
            raddr = bus.trace__branch_target;
        end else if (sync_pending) begin
            rtype   = REC_SYNC;
            rcnt    = '0;
            cnt_nxt = CNT_W'(1);
        end else if (n == CNT_MAX) begin
            rtype = REC_SAT;
        end else begin
            gen     = 1'b0;
            cnt_nxt = n;
        end
    end

    // Sync flag marks any record that doubles as the restart point.
    assign rec = {rtype, 14'(rcnt), dropped, sync_pending,
                  14'd0, raddr};

    assign gen_rec   = ev & gen;
    assign full      = (level == LVL_FULL);
    assign push_ok   = gen_rec & ~full;
    assign push_drop = gen_rec & full;
    assign rd_valid  = (level != '0);
    assign pop       = rd_valid & bus.rd_ready & clk__enable;

    assign bus.rd_valid   = rd_valid;
    assign bus.rd_data    = rd_valid ? mem[rd_ptr] : 64'd0;
    assign bus.fifo_level = level;
    assign bus.dropped    = dropped;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= rec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            sync_pending <= 1'b1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            dropped      <= 1'b0;
        end else if (clk__enable) begin
            if (!bus.trace_enable) begin
                cnt          <= '0;
                sync_pending <= 1'b1;
            end else if (ev) begin
                cnt <= cnt_nxt;
                if (gen) begin
                    sync_pending <= 1'b0;
                end
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (push_ok && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push_ok) begin
                level <= level - 1'b1;
            end

            if (push_drop) begin
                dropped <= 1'b1;
            end else if (push_ok) begin
                dropped <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_riscv_i32_trace_pack.sv
// Scoreboard bench: directed trace stimulus queues hand-built records,
// per-DUT monitors pop and compare whenever a record is read out.
module tb_riscv_i32_trace_pack;
    logic clk = 1'b0;
    logic clk_en;
    logic reset;

    always #5 clk = ~clk;

    riscv_i32_trace_pack_if #(.DEPTH(16)) ia ();
    riscv_i32_trace_pack_if #(.DEPTH(16)) ib ();

    riscv_i32_trace_pack #(.DEPTH(16), .CNT_W(14)) dut_a (
        .clk        (clk),
        .clk__enable(clk_en),
        .reset      (reset),
        .bus        (ia.slave)
    );

    riscv_i32_trace_pack #(.DEPTH(16), .CNT_W(4)) dut_b (
        .clk        (clk),
        .clk__enable(clk_en),
        .reset      (reset),
        .bus        (ib.slave)
    );

    logic [63:0] qa[$];
    logic [63:0] qb[$];
    int errors = 0;
    int checks = 0;

    function automatic logic [63:0] mk(
        input logic [1:0] t, input int c,
        input logic d, input logic s, input logic [31:0] a);
        logic [13:0] c14;
        c14 = c[13:0];
        return {t, c14, d, s, 14'd0, a};
    endfunction

    task automatic check(input string name,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && clk_en && ia.rd_valid && ia.rd_ready) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_a: unexpected record %h", ia.rd_data);
            end else begin
                check("mon_a", ia.rd_data, qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && clk_en && ib.rd_valid && ib.rd_ready) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_b: unexpected record %h", ib.rd_data);
            end else begin
                check("mon_b", ib.rd_data, qb.pop_front());
            end
        end
    end

    task automatic ins_a(input logic [31:0] pc,
                         input logic br = 1'b0,
                         input logic [31:0] tgt = 32'h0,
                         input logic tr = 1'b0);
        ia.trace__instr_valid   = 1'b1;
        ia.trace__instr_pc      = pc;
        ia.trace__branch_taken  = br;
        ia.trace__branch_target = tgt;
        ia.trace__trap          = tr;
        @(posedge clk);
        #1;
        ia.trace__instr_valid  = 1'b0;
        ia.trace__branch_taken = 1'b0;
        ia.trace__trap         = 1'b0;
    endtask

    task automatic ins_b(input logic [31:0] pc,
                         input logic br = 1'b0,
                         input logic [31:0] tgt = 32'h0);
        ib.trace__instr_valid   = 1'b1;
        ib.trace__instr_pc      = pc;
        ib.trace__branch_taken  = br;
        ib.trace__branch_target = tgt;
        ib.trace__trap          = 1'b0;
        @(posedge clk);
        #1;
        ib.trace__instr_valid  = 1'b0;
        ib.trace__branch_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a();
        for (int i = 0; i < 64; i++) begin
            if (qa.size() == 0) break;
            tick();
        end
        check("drain_a", 64'(qa.size()), 64'd0);
    endtask

    task automatic drain_b();
        for (int i = 0; i < 64; i++) begin
            if (qb.size() == 0) break;
            tick();
        end
        check("drain_b", 64'(qb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk_en = 1'b1;
        reset  = 1'b1;
        ia.trace__instr_valid   = 1'b0;
        ia.trace__instr_pc      = '0;
        ia.trace__branch_taken  = 1'b0;
        ia.trace__branch_target = '0;
        ia.trace__trap          = 1'b0;
        ia.riscv_clk_enable     = 1'b1;
        ia.trace_enable         = 1'b1;
        ia.rd_ready             = 1'b0;
        ib.trace__instr_valid   = 1'b0;
        ib.trace__instr_pc      = '0;
        ib.trace__branch_taken  = 1'b0;
        ib.trace__branch_target = '0;
        ib.trace__trap          = 1'b0;
        ib.riscv_clk_enable     = 1'b1;
        ib.trace_enable         = 1'b1;
        ib.rd_ready             = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_valid", 64'(ia.rd_valid), 64'd0);
        check("rst_data", ia.rd_data, 64'd0);
        check("rst_level", 64'(ia.fifo_level), 64'd0);
        check("rst_dropped", 64'(ia.dropped), 64'd0);

        // sync on first instruction, then quiet sequential run
        qa.push_back(mk(2'd0, 0, 1'b0, 1'b1, 32'h100));
        ins_a(32'h100);
        check("t1_level_sync", 64'(ia.fifo_level), 64'd1);
        for (int i = 1; i < 5; i++) ins_a(32'h100 + 32'(4 * i));
        check("t1_level_run", 64'(ia.fifo_level), 64'd1);
        check("t1_head", ia.rd_data, mk(2'd0, 0, 1'b0, 1'b1, 32'h100));
        ia.rd_ready = 1'b1;
        tick();
        check("t1_level_pop", 64'(ia.fifo_level), 64'd0);

        ins_a(32'h114);
        ins_a(32'h118);
        qa.push_back(mk(2'd1, 8, 1'b0, 1'b0, 32'h2000));
        ins_a(32'h11c, 1'b1, 32'h2000);
        drain_a();

        // restart, first instr traps; then trap beats branch
        ia.trace_enable = 1'b0;
        tick();
        ia.trace_enable = 1'b1;
        qa.push_back(mk(2'd2, 1, 1'b0, 1'b1, 32'h80));
        ins_a(32'h80, 1'b0, 32'h0, 1'b1);
        qa.push_back(mk(2'd2, 1, 1'b0, 1'b0, 32'h84));
        ins_a(32'h84, 1'b1, 32'h3000, 1'b1);
        drain_a();

        // gated ticks must not touch state
        ia.riscv_clk_enable = 1'b0;
        ins_a(32'h200, 1'b0, 32'h0, 1'b1);
        ins_a(32'h204, 1'b1, 32'h5000);
        ins_a(32'h208);
        ia.riscv_clk_enable = 1'b1;
        clk_en = 1'b0;
        ins_a(32'h300, 1'b0, 32'h0, 1'b1);
        clk_en = 1'b1;
        check("t6_gated_level", 64'(ia.fifo_level), 64'd0);
        ins_a(32'h88);
        qa.push_back(mk(2'd1, 2, 1'b0, 1'b0, 32'h6000));
        ins_a(32'h8c, 1'b1, 32'h6000);
        drain_a();

        ins_a(32'h90);
        ia.trace_enable = 1'b0;
        tick();
        ia.trace_enable = 1'b1;
        qa.push_back(mk(2'd0, 0, 1'b0, 1'b1, 32'h94));
        ins_a(32'h94);
        qa.push_back(mk(2'd1, 2, 1'b0, 1'b0, 32'h3ff0));
        ins_a(32'h98, 1'b1, 32'h3ff0);
        drain_a();

        // overflow: 18 records into 16 entries
        ia.rd_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) qa.push_back(mk(2'd1, 1, 1'b0, 1'b0, 32'h4000 + 32'(4 * i)));
            ins_a(32'h400 + 32'(4 * i), 1'b1, 32'h4000 + 32'(4 * i));
        end
        check("t5_level_full", 64'(ia.fifo_level), 64'd16);
        check("t5_dropped_set", 64'(ia.dropped), 64'd1);
        ia.rd_ready = 1'b1;
        tick();
        ia.rd_ready = 1'b0;
        check("t5_level_pop", 64'(ia.fifo_level), 64'd15);
        qa.push_back(mk(2'd1, 1, 1'b1, 1'b0, 32'h7000));
        ins_a(32'h500, 1'b1, 32'h7000);
        check("t5_dropped_clr", 64'(ia.dropped), 64'd0);
        check("t5_level_refill", 64'(ia.fifo_level), 64'd16);
        ia.rd_ready = 1'b1;
        drain_a();

        // reset mid-stream discards buffered records
        ia.rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) ins_a(32'h700 + 32'(4 * i), 1'b1, 32'h8000);
        check("t6_level5", 64'(ia.fifo_level), 64'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_level", 64'(ia.fifo_level), 64'd0);
        check("t6_rst_valid", 64'(ia.rd_valid), 64'd0);
        check("t6_rst_data", ia.rd_data, 64'd0);
        qa.push_back(mk(2'd0, 0, 1'b0, 1'b1, 32'h600));
        ins_a(32'h600);
        ia.rd_ready = 1'b1;
        drain_a();

        // narrow counter saturates at 15
        qb.push_back(mk(2'd0, 0, 1'b0, 1'b1, 32'h1000));
        ins_b(32'h1000);
        for (int k = 1; k < 14; k++) ins_b(32'h1000 + 32'(4 * k));
        check("t4_no_early", 64'(qb.size()), 64'd0);
        qb.push_back(mk(2'd3, 15, 1'b0, 1'b0, 32'h1038));
        ins_b(32'h1038);
        for (int k = 15; k < 18; k++) ins_b(32'h1000 + 32'(4 * k));
        qb.push_back(mk(2'd1, 4, 1'b0, 1'b0, 32'h9000));
        ins_b(32'h1048, 1'b1, 32'h9000);
        drain_b();

        repeat (3) tick();
        check("end_qa_empty", 64'(qa.size()), 64'd0);
        check("end_fifo_a", 64'(ia.fifo_level), 64'd0);
        check("end_fifo_b", 64'(ib.fifo_level), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
